// File: rtl/fir_phase_mac.sv
// One polyphase FIR phase: a delay line and a coefficient bank shared by a single
// multiply-accumulate unit that walks the taps one per clock, then saturates the sum.
module fir_phase_mac #(
  parameter int W_IN   = 7,
  parameter int C_W    = 5,
  parameter int Y_OUT  = 20,
  parameter int N_TAPS = 4,
  parameter int ACC_W  = 25,
  localparam int AW    = (N_TAPS > 1) ? $clog2(N_TAPS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [W_IN-1:0]  s_data,
  input  logic             coef_we,
  input  logic [AW-1:0]    coef_addr,
  input  logic [C_W-1:0]   coef_wdata,
  output logic             coef_err,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [Y_OUT-1:0] m_data,
  output logic             m_sat
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MAC  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  localparam int PW = W_IN + C_W;
  localparam int EW = (ACC_W > Y_OUT) ? ACC_W : Y_OUT;
  localparam logic signed [EW-1:0] Y_MAX = {{(EW-Y_OUT+1){1'b0}}, {(Y_OUT-1){1'b1}}};
  localparam logic signed [EW-1:0] Y_MIN = {{(EW-Y_OUT+1){1'b1}}, {(Y_OUT-1){1'b0}}};

  logic [1:0]              state_reg;
  logic signed [W_IN-1:0]  x_reg [N_TAPS];
  logic signed [C_W-1:0]   c_reg [N_TAPS];
  logic signed [ACC_W-1:0] acc_reg;
  logic [AW-1:0]           idx_reg;
  logic                    m_valid_reg;
  logic [Y_OUT-1:0]        m_data_reg;
  logic                    m_sat_reg;
  logic                    coef_err_reg;

  logic                    addr_ok;
  logic [N_TAPS-1:0]       coef_hit;
  logic signed [PW-1:0]    x_ext;
  logic signed [PW-1:0]    c_ext;
  logic signed [PW-1:0]    prod;
  logic signed [ACC_W-1:0] sum;
  logic signed [EW-1:0]    sum_ext;
  logic                    sat_hi;
  logic                    sat_lo;

  assign addr_ok = int'(coef_addr) < N_TAPS;

  // Writes only land while idle so a sum in flight never mixes old and new taps.
  genvar gi;
  generate
    for (gi = 0; gi < N_TAPS; gi++) begin : g_coef_hit
      assign coef_hit[gi] = coef_we && (state_reg == ST_IDLE) && (coef_addr == AW'(gi));
    end
  endgenerate

  assign x_ext   = PW'(x_reg[idx_reg]);
  assign c_ext   = PW'(c_reg[idx_reg]);
  assign prod    = x_ext * c_ext;
  assign sum     = acc_reg + ACC_W'(prod);
  assign sum_ext = EW'(sum);
  assign sat_hi  = sum_ext > Y_MAX;
  assign sat_lo  = sum_ext < Y_MIN;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      acc_reg      <= '0;
      idx_reg      <= '0;
      m_valid_reg  <= 1'b0;
      m_data_reg   <= '0;
      m_sat_reg    <= 1'b0;
      coef_err_reg <= 1'b0;
      for (int k = 0; k < N_TAPS; k++) begin
        x_reg[k] <= '0;
        c_reg[k] <= '0;
      end
    end else begin
      coef_err_reg <= coef_we && addr_ok && (state_reg != ST_IDLE);
      for (int k = 0; k < N_TAPS; k++) begin
        if (coef_hit[k]) c_reg[k] <= coef_wdata;
      end
      case (state_reg)
        ST_IDLE: begin
          if (s_valid) begin
            x_reg[0] <= s_data;
            for (int k = 1; k < N_TAPS; k++) x_reg[k] <= x_reg[k-1];
            acc_reg   <= '0;
            idx_reg   <= '0;
            state_reg <= ST_MAC;
          end
        end
        ST_MAC: begin
          acc_reg <= sum;
          idx_reg <= idx_reg + AW'(1);
          if (idx_reg == AW'(N_TAPS - 1)) begin
            m_data_reg  <= sat_hi ? Y_MAX[Y_OUT-1:0] :
                           sat_lo ? Y_MIN[Y_OUT-1:0] : sum_ext[Y_OUT-1:0];
            m_sat_reg   <= sat_hi || sat_lo;
            m_valid_reg <= 1'b1;
            state_reg   <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (m_ready) begin
            m_valid_reg <= 1'b0;
            state_reg   <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign s_ready  = (state_reg == ST_IDLE);
  assign coef_err = coef_err_reg;
  assign m_valid  = m_valid_reg;
  assign m_data   = m_data_reg;
  assign m_sat    = m_sat_reg;

endmodule
